// File: rtl/castor_dbg_pkg.sv
// Shared types for the castor32rv debug step/run controller.
// Provides: command opcodes, halt causes, controller states and the
// breakpoint-index width helper used by the controller port list.
package castor_dbg_pkg;

  // Debug command opcodes; encodings 6 and 7 are treated as NOP.
  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_HALT   = 3'd1,
    OP_STEP   = 3'd2,
    OP_RUN    = 3'd3,
    OP_SET_BP = 3'd4,
    OP_CLR_BP = 3'd5
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_CMD        = 2'd1,
    CAUSE_STEP_DONE  = 2'd2,
    CAUSE_BREAKPOINT = 2'd3
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_STEP   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int CMD_ARG_W = 32;

  // Slot index width; a single slot still gets a 1-bit index port.
  function automatic int bp_idx_w(input int num_bp);
    return (num_bp > 1) ? $clog2(num_bp) : 1;
  endfunction

endpackage

// File: rtl/castor_bp_match.sv
// PC breakpoint comparator bank: flags a hit when any enabled slot matches pc_addr.
// Ports: pc_addr (current PC), bp_en (per-slot enable), bp_addr (per-slot address),
//        bp_hit (combinational OR of all enabled matches).
module castor_bp_match #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BP     = 2
) (
  input  logic [ADDR_WIDTH-1:0]             pc_addr,
  input  logic [NUM_BP-1:0]                 bp_en,
  input  logic [NUM_BP-1:0][ADDR_WIDTH-1:0] bp_addr,
  output logic                              bp_hit
);

  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (pc_addr == bp_addr[i])) bp_hit = 1'b1;
    end
  end

endmodule

// File: rtl/castor_step_ctrl.sv
// Debug step/run controller driving the castor32rv core clock-enable.
// Ports: cmd_* valid/ready command port (HALT/STEP/RUN/SET_BP/CLR_BP), pc_addr from core;
//        core_en, halted, halt_cause, cycles, evt_valid (1-cycle halt event) to core/host.
module castor_step_ctrl
  import castor_dbg_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int CYCLE_WIDTH = 32,
  parameter int NUM_BP      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [bp_idx_w(NUM_BP)-1:0]   cmd_idx,
  input  logic [CMD_ARG_W-1:0]          cmd_arg,
  input  logic [ADDR_WIDTH-1:0]         pc_addr,
  output logic                          core_en,
  output logic                          halted,
  output logic [1:0]                    halt_cause,
  output logic [CYCLE_WIDTH-1:0]        cycles,
  output logic                          evt_valid
);

  localparam int IDX_W = bp_idx_w(NUM_BP);

  state_e                          state_q, state_d;
  halt_cause_e                     cause_q, cause_d;
  logic                            first_q, first_d;
  logic                            evt_q, evt_d;
  logic [CMD_ARG_W-1:0]            rem_q, rem_d;
  logic [CYCLE_WIDTH-1:0]          cyc_q, cyc_d;
  logic [NUM_BP-1:0]               bp_en_q, bp_en_d;
  logic [NUM_BP-1:0][ADDR_WIDTH-1:0] bp_addr_q, bp_addr_d;

  logic running, op_stalls, accept, bp_hit, bp_take;

  castor_bp_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BP     (NUM_BP)
  ) u_bp_match (
    .pc_addr (pc_addr),
    .bp_en   (bp_en_q),
    .bp_addr (bp_addr_q),
    .bp_hit  (bp_hit)
  );

  assign running   = (state_q != ST_HALTED);
  // STEP/RUN cannot be queued behind an active run; everything else is absorbed.
  assign op_stalls = (cmd_op == OP_STEP) || (cmd_op == OP_RUN);
  assign cmd_ready = !running || !op_stalls;
  assign accept    = cmd_valid && cmd_ready;
  // The first cycle after resume ignores a hit so the core can leave the bp address.
  assign bp_take   = bp_hit && !first_q;
  assign core_en   = running && !bp_take;

  assign halted     = !running;
  assign halt_cause = cause_q;
  assign cycles     = cyc_q;
  assign evt_valid  = evt_q;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    first_d   = first_q;
    evt_d     = 1'b0;
    rem_d     = rem_q;
    cyc_d     = cyc_q;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;

    // Breakpoint table updates are legal in any state; out-of-range slots match nothing.
    if (accept && ((cmd_op == OP_SET_BP) || (cmd_op == OP_CLR_BP))) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (cmd_idx == IDX_W'(i)) begin
          bp_en_d[i] = (cmd_op == OP_SET_BP);
          if (cmd_op == OP_SET_BP) bp_addr_d[i] = cmd_arg[ADDR_WIDTH-1:0];
        end
      end
    end

    if (!running) begin
      if (accept && (cmd_op == OP_STEP)) begin
        state_d = ST_STEP;
        rem_d   = (cmd_arg == '0) ? CMD_ARG_W'(1) : cmd_arg;
        first_d = 1'b1;
        cause_d = CAUSE_NONE;
      end else if (accept && (cmd_op == OP_RUN)) begin
        state_d = ST_RUN;
        first_d = 1'b1;
        cause_d = CAUSE_NONE;
      end
    end else begin
      first_d = 1'b0;
      if (core_en) begin
        cyc_d = cyc_q + CYCLE_WIDTH'(1);
        if (state_q == ST_STEP) rem_d = rem_q - CMD_ARG_W'(1);
      end
      // Halt priority: breakpoint, then accepted HALT, then step exhaustion.
      if (bp_take) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_BREAKPOINT;
        evt_d   = 1'b1;
      end else if (accept && (cmd_op == OP_HALT)) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_CMD;
        evt_d   = 1'b1;
      end else if ((state_q == ST_STEP) && core_en && (rem_q == CMD_ARG_W'(1))) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_STEP_DONE;
        evt_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HALTED;
      cause_q   <= CAUSE_NONE;
      first_q   <= 1'b0;
      evt_q     <= 1'b0;
      rem_q     <= '0;
      cyc_q     <= '0;
      bp_en_q   <= '0;
      bp_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      first_q   <= first_d;
      evt_q     <= evt_d;
      rem_q     <= rem_d;
      cyc_q     <= cyc_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
    end
  end

endmodule

// File: tb/tb_castor_step_ctrl.sv
// Directed bench for castor_step_ctrl with a trivial core model (pc += 4 per core_en edge).
// Ports: drives clk/rst/cmd_*/pc_addr, observes core_en/halted/halt_cause/cycles/evt_valid.
module tb_castor_step_ctrl;
  import castor_dbg_pkg::*;

  localparam int AW = 32;
  localparam int CW = 32;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [0:0]    cmd_idx = 1'b0;
  logic [31:0]   cmd_arg = 32'd0;
  logic [AW-1:0] pc_addr;
  logic          core_en;
  logic          halted;
  logic [1:0]    halt_cause;
  logic [CW-1:0] cycles;
  logic          evt_valid;

  logic pc_rewind = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_cnt  = 0;
  int   evt_cnt = 0;
  int   en0;
  int   evt0;

  castor_step_ctrl #(
    .ADDR_WIDTH  (AW),
    .CYCLE_WIDTH (CW),
    .NUM_BP      (NB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_idx    (cmd_idx),
    .cmd_arg    (cmd_arg),
    .pc_addr    (pc_addr),
    .core_en    (core_en),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cycles     (cycles),
    .evt_valid  (evt_valid)
  );

  always #5 clk = ~clk;

  // Core model: PC register advancing by one instruction per enabled edge.
  always @(posedge clk) begin
    if (pc_rewind) pc_addr <= '0;
    else if (core_en) pc_addr <= pc_addr + 32'd4;
  end

  always @(negedge clk) begin
    if (core_en) en_cnt++;
    if (evt_valid) evt_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one command from a negedge and hold it until accepted at a posedge.
  task automatic send(input logic [2:0] op, input logic [0:0] idx, input logic [31:0] arg);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_arg   = arg;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  task automatic wait_halt(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!halted && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_halted"}, {63'd0, halted}, 64'd1);
    chk({tag, "_evt"}, {63'd0, evt_valid}, 64'd1);
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_halted", {63'd0, halted}, 64'd1);
    chk("rst_core_en", {63'd0, core_en}, 64'd0);
    chk("rst_cycles", {32'd0, cycles}, 64'd0);
    chk("rst_cause", {62'd0, halt_cause}, 64'd0);
    chk("rst_evt", {63'd0, evt_valid}, 64'd0);
    rst = 1'b0;
    pc_rewind = 1'b0;

    // 2: STEP 3
    send(OP_STEP, 1'b0, 32'd3);
    en0 = en_cnt; evt0 = evt_cnt;
    wait_halt("step3");
    repeat (2) @(negedge clk);
    chk("step3_en_cycles", 64'(en_cnt - en0), 64'd3);
    chk("step3_pc", {32'd0, pc_addr}, 64'd12);
    chk("step3_cycles", {32'd0, cycles}, 64'd3);
    chk("step3_cause", {62'd0, halt_cause}, 64'd2);
    chk("step3_evt_count", 64'(evt_cnt - evt0), 64'd1);

    // HALT while halted changes nothing and raises no event
    evt0 = evt_cnt;
    send(OP_HALT, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    chk("halt_idle_cause", {62'd0, halt_cause}, 64'd2);
    chk("halt_idle_halted", {63'd0, halted}, 64'd1);
    chk("halt_idle_evt", 64'(evt_cnt - evt0), 64'd0);

    // 3: breakpoint at 0x10, then resume over it
    send(OP_SET_BP, 1'b0, 32'h10);
    send(OP_RUN, 1'b0, 32'd0);
    wait_halt("bp");
    chk("bp_pc", {32'd0, pc_addr}, 64'h10);
    chk("bp_cause", {62'd0, halt_cause}, 64'd3);
    chk("bp_cycles", {32'd0, cycles}, 64'd4);
    send(OP_STEP, 1'b0, 32'd1);
    wait_halt("bp_step");
    chk("bp_step_pc", {32'd0, pc_addr}, 64'h14);
    chk("bp_step_cycles", {32'd0, cycles}, 64'd5);
    chk("bp_step_cause", {62'd0, halt_cause}, 64'd2);

    // 4: RUN, STEP stalls, HALT accepted in the first run cycle still executes
    send(OP_RUN, 1'b0, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_STEP;
    cmd_arg   = 32'd2;
    #1;
    chk("run_step_stall", {63'd0, cmd_ready}, 64'd0);
    cmd_op = OP_HALT;
    #1;
    chk("run_halt_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    wait_halt("cmd");
    chk("cmd_cause", {62'd0, halt_cause}, 64'd1);
    chk("cmd_cycles", {32'd0, cycles}, 64'd6);
    chk("cmd_pc", {32'd0, pc_addr}, 64'h18);

    // 5: STEP 0 is one instruction; cleared bp no longer stops RUN
    send(OP_STEP, 1'b0, 32'd0);
    en0 = en_cnt;
    wait_halt("step0");
    chk("step0_en_cycles", 64'(en_cnt - en0), 64'd1);
    chk("step0_cycles", {32'd0, cycles}, 64'd7);
    chk("step0_cause", {62'd0, halt_cause}, 64'd2);
    send(OP_CLR_BP, 1'b0, 32'd0);
    @(negedge clk); pc_rewind = 1'b1;
    @(negedge clk); pc_rewind = 1'b0;
    send(OP_RUN, 1'b0, 32'd0);
    repeat (6) @(negedge clk);
    chk("clr_bp_running", {63'd0, halted}, 64'd0);
    chk("clr_bp_pc", {32'd0, pc_addr}, 64'h14);
    send(OP_HALT, 1'b0, 32'd0);
    wait_halt("clr_halt");
    chk("clr_halt_cycles", {32'd0, cycles}, 64'd14);
    chk("clr_halt_cause", {62'd0, halt_cause}, 64'd1);

    // 6: reset mid-RUN with a breakpoint armed
    send(OP_SET_BP, 1'b1, 32'h40);
    send(OP_RUN, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    evt0 = evt_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_halted", {63'd0, halted}, 64'd1);
    chk("mid_rst_core_en", {63'd0, core_en}, 64'd0);
    chk("mid_rst_cycles", {32'd0, cycles}, 64'd0);
    chk("mid_rst_cause", {62'd0, halt_cause}, 64'd0);
    chk("mid_rst_evt", {63'd0, evt_valid}, 64'd0);
    rst = 1'b0;
    send(OP_RUN, 1'b0, 32'd0);
    repeat (10) @(negedge clk);
    chk("post_rst_bp_cleared", {63'd0, halted}, 64'd0);
    chk("post_rst_cycles", {32'd0, cycles}, 64'd9);
    chk("post_rst_no_evt", 64'(evt_cnt - evt0), 64'd0);
    send(OP_HALT, 1'b0, 32'd0);
    wait_halt("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
